// File: rtl/param_stream_loader.sv
// Purpose: streams words into the image / conv-kernel / FC-weight regions and serves a registered read port.
// Latency: one word written per accepted beat; done one cycle after the final beat; reads return one cycle after rd_en.
// Backpressure: in_ready is high in every load state, so the only stall source is the producer dropping in_valid.
//
// Ports: clk/rst (async active-low); start/load_sel begin a load; in_valid/in_ready/in_data/in_last form the
// write stream; busy/done/err/loaded report status; rd_en/rd_region/rd_addr -> rd_data/rd_valid is the read port.
module param_stream_loader #(
    parameter int DW     = 32,
    parameter int IMG    = 28,
    parameter int K      = 5,
    parameter int NCH    = 8,
    parameter int FC_LEN = 1152,
    parameter int NCLS   = 10,
    parameter int AW     = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    load_sel,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [2:0]    loaded,
    input  logic          rd_en,
    input  logic [1:0]    rd_region,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid
);

    localparam int IMG_N   = IMG * IMG;
    localparam int CONV_N  = NCH * K * K;
    localparam int FC_N    = NCLS * FC_LEN;
    localparam int IMG_IW  = $clog2(IMG_N);
    localparam int CONV_IW = $clog2(CONV_N);
    localparam int FC_IW   = $clog2(FC_N);

    localparam logic [AW-1:0] IMG_SZ  = AW'(IMG_N);
    localparam logic [AW-1:0] CONV_SZ = AW'(CONV_N);
    localparam logic [AW-1:0] FC_SZ   = AW'(FC_N);

    typedef enum logic [2:0] {IDLE, L_IMG, L_CONV, L_FC, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cnt;
    logic          all_mode;

    logic          beat, region_last, final_region, abort, finish, advance;
    logic [2:0]    region_mask, sel_mask;
    logic [DW-1:0] rd_word;

    logic [DW-1:0] img_mem  [IMG_N];
    logic [DW-1:0] conv_mem [CONV_N];
    logic [DW-1:0] fc_mem   [FC_N];

    // Per-beat classification of the word currently on the stream.
    always_comb begin
        region_last = 1'b0;
        region_mask = 3'b000;
        case (state)
            L_IMG:   begin region_last = (cnt == IMG_SZ - 1'b1);  region_mask = 3'b001; end
            L_CONV:  begin region_last = (cnt == CONV_SZ - 1'b1); region_mask = 3'b010; end
            L_FC:    begin region_last = (cnt == FC_SZ - 1'b1);   region_mask = 3'b100; end
            default: ;
        endcase
        case (load_sel)
            2'd0:    sel_mask = 3'b001;
            2'd1:    sel_mask = 3'b010;
            2'd2:    sel_mask = 3'b100;
            default: sel_mask = 3'b111;
        endcase
        beat         = in_valid & in_ready;
        final_region = !all_mode || (state == L_FC);
        // in_last anywhere but the final beat of the whole burst kills the load.
        abort        = beat && in_last && !(region_last && final_region);
        finish       = beat && !abort && region_last && final_region;
        advance      = beat && !abort && region_last && !final_region;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (load_sel)
                        2'd1:    state_nxt = L_CONV;
                        2'd2:    state_nxt = L_FC;
                        default: state_nxt = L_IMG;
                    endcase
                end
            end
            L_IMG, L_CONV, L_FC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (abort)
                    state_nxt = IDLE;
                else if (finish)
                    state_nxt = DONE;
                else if (advance)
                    state_nxt = (state == L_IMG) ? L_CONV : L_FC;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Counter and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            all_mode <= 1'b0;
            err      <= 1'b0;
            loaded   <= 3'b000;
        end else if (state == IDLE && start) begin
            cnt      <= '0;
            all_mode <= (load_sel == 2'd3);
            err      <= 1'b0;
            loaded   <= loaded & ~sel_mask;
        end else if (beat) begin
            if (abort) begin
                err <= 1'b1;
            end else if (region_last) begin
                loaded <= loaded | region_mask;
                cnt    <= '0;
                // Missing in_last still completes the load, but is flagged.
                if (finish && !in_last)
                    err <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Storage: no reset so contents survive a reset mid-load.
    always_ff @(posedge clk) begin
        if (beat) begin
            case (state)
                L_IMG:   img_mem[cnt[IMG_IW-1:0]]   <= in_data;
                L_CONV:  conv_mem[cnt[CONV_IW-1:0]] <= in_data;
                L_FC:    fc_mem[cnt[FC_IW-1:0]]     <= in_data;
                default: ;
            endcase
        end
    end

    // Out-of-range addresses and the reserved region read as zero.
    always_comb begin
        rd_word = '0;
        case (rd_region)
            2'd0: if (rd_addr < IMG_SZ)  rd_word = img_mem[rd_addr[IMG_IW-1:0]];
            2'd1: if (rd_addr < CONV_SZ) rd_word = conv_mem[rd_addr[CONV_IW-1:0]];
            2'd2: if (rd_addr < FC_SZ)   rd_word = fc_mem[rd_addr[FC_IW-1:0]];
            default: ;
        endcase
    end

    // The arrays are sampled before this edge's write lands, giving read-before-write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_word;
        end
    end

endmodule

// File: doc/param_stream_loader.md
Name: param_stream_loader

Overview:
- Run-time replacement for the file-based image/weight loader in the CNN test path.
- Accepts a valid/ready word stream and writes it into three on-chip regions: input image (IMG×IMG), conv kernels (NCH×K×K), and FC weights (NCLS×FC_LEN).
- Regions are loaded individually or back-to-back in one burst.
- Provides a registered read port for the conv and FC engines.

Parameters:
- DW, 32, data/weight word width (two's complement for weights).
- IMG, 28, image side length.
- K, 5, conv kernel side length.
- NCH, 8, number of conv kernels.
- FC_LEN, 1152, FC weights per class.
- NCLS, 10, number of FC classes.
- AW, 14, read address width; must satisfy 2^AW ≥ max(IMG², NCH·K², NCLS·FC_LEN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load.
- load_sel  in  2  region select: 0 = image, 1 = conv, 2 = fc, 3 = all (image→conv→fc).
- in_valid  in  1  stream word valid.
- in_ready  out  1  loader accepts a word this cycle.
- in_data  in  DW  stream word.
- in_last  in  1  marks the final word of the burst.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse on successful load completion.
- err  out  1  sticky length-mismatch flag; cleared by the next accepted start.
- loaded  out  3  per-region loaded flags: bit0 = image, bit1 = conv, bit2 = fc.
- rd_en  in  1  read request.
- rd_region  in  2  0 = image, 1 = conv, 2 = fc; 3 is reserved and reads 0.
- rd_addr  in  AW  linear word address; row-major, region base 0.
- rd_data  out  DW  read data.
- rd_valid  out  1  rd_data valid.

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE, in_ready = 0, busy = 0, done = 0, err = 0, loaded = 0, rd_data = 0, rd_valid = 0. Memory contents are not cleared.
- States and transitions:
  - IDLE: on start, go to L_IMG, L_CONV or L_FC according to load_sel (3 → L_IMG). The accepted start clears err and clears the loaded bit(s) of the target region(s).
  - L_IMG / L_CONV / L_FC: a word is accepted when in_valid & in_ready. It is written to the current region at cnt, then cnt increments. cnt resets to 0 on every region entry.
  - Region end: a beat is the region's last when cnt = IMG²−1, NCH·K²−1 or NCLS·FC_LEN−1 respectively. On that beat the region's loaded bit is set.
    - load_sel = 3: image → L_CONV, conv → L_FC.
    - Otherwise: go to DONE.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- Outputs by state:
  - in_ready = 1 exactly in the L_* states; busy = 1 in L_* and DONE.
  - start while busy is ignored; it has no effect on state or err.
- in_last rules:
  - in_last is required on the final beat of the whole burst (fc end when load_sel = 3, else the end of the selected region).
  - in_last on any earlier beat: that word is still written, err = 1, the current region's loaded bit stays 0, go to IDLE (no done).
  - Final beat without in_last: load completes normally, done pulses, and err = 1.
- Stalls: in_valid low holds cnt and state; there is no timeout.
- Write ordering:
  - Image: addr = row·IMG + col.
  - Conv: addr = ch·K² + row·K + col.
  - FC: addr = cls·FC_LEN + idx.
  - This matches stream order.
- Read port:
  - Latency 1: rd_en at cycle t gives rd_data and rd_valid = 1 at t+1.
  - rd_valid = 0 when rd_en = 0, and rd_data holds its last value.
  - Reads are allowed in any state.
  - Read and write to the same region/address in the same cycle returns the old value (read-before-write).
  - rd_addr beyond the region size returns 0 with rd_valid = 1.
- Arithmetic: words are stored bit-exact with no sign handling inside; signedness is the consumer's concern. cnt width = AW.
- Reset mid-load: aborts immediately, all flags are cleared, and partially written words remain in memory.

Test Plan:
- Reset, then start with load_sel = 0 and 784 words 0..783, in_last on word 783:
  - done pulses one cycle after the last beat; loaded = 3'b001.
  - rd image addr 29 → rd_data = 29 one cycle later.
- load_sel = 3, stream 784 + 200 + 11520 words with value = global index, in_last on the final word only:
  - loaded = 3'b111, single done pulse.
  - Conv addr 0 reads 784; fc addr 11519 reads 12503.
- load_sel = 1, in_last asserted on word 99 of 200:
  - err = 1, no done, loaded[1] = 0, in_ready = 0 next cycle.
  - Next start clears err.
- Image load with in_valid toggled 1/0 every cycle:
  - Completes after 1568 stream cycles.
  - Image addr 783 reads 783; cnt never skips or repeats.
- Assert rst low after word 300 of an image load:
  - All outputs 0 asynchronously; loaded = 0.
  - Image addr 10 reads 10 after release; start during a subsequent busy period is ignored.
- Preload image (addr 5 = 5), start a new image load, and read addr 5 in the cycle that writes 0xFFFFFFFB:
  - rd_data = 5.
  - The next read of addr 5 returns 0xFFFFFFFB.
